// File: rtl/dispatch_alloc_ctrl_pkg.sv
// Shared constants and types for the dispatch allocation controller.
package dispatch_alloc_ctrl_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_W     = 3;
    localparam int LQ_DEPTH  = 4;
    localparam int LQ_W      = 2;
    localparam int SQ_DEPTH  = 4;
    localparam int SQ_W      = 2;

    localparam logic [2:0] FU_ALU   = 3'd0;
    localparam logic [2:0] FU_BR    = 3'd2;
    localparam logic [2:0] FU_LOAD  = 3'd6;
    localparam logic [2:0] FU_STORE = 3'd7;

    // Which memory queue (if any) an instruction needs a slot in.
    typedef enum logic [1:0] {
        ALLOC_OTHER = 2'd0,
        ALLOC_LD    = 2'd1,
        ALLOC_ST    = 2'd2
    } alloc_kind_e;

    function automatic alloc_kind_e classify(input logic [2:0] fu_sel);
        alloc_kind_e kind;
        kind = ALLOC_OTHER;
        if (fu_sel == FU_LOAD) begin
            kind = ALLOC_LD;
        end else if (fu_sel == FU_STORE) begin
            kind = ALLOC_ST;
        end
        return kind;
    endfunction

endpackage

// File: rtl/dispatch_alloc_ctrl_if.sv
// Decode <-> allocation controller bundle: requests in, pointers and readies out.
interface dispatch_alloc_ctrl_if;
    import dispatch_alloc_ctrl_pkg::*;

    logic             alloc_valid;
    logic [2:0]       alloc_fu_sel;
    logic             rob_ready;
    logic             ld_ready;
    logic             st_ready;
    logic [ROB_W-1:0] rob_idx;
    logic [LQ_W-1:0]  LQ_tail;
    logic [SQ_W-1:0]  SQ_tail;
    logic [ROB_W-1:0] rob_head;
    logic             commit_valid;
    logic             mispredict;
    logic [ROB_W-1:0] mispredict_rob_idx;

    modport master (
        output alloc_valid, alloc_fu_sel, commit_valid, mispredict, mispredict_rob_idx,
        input  rob_ready, ld_ready, st_ready, rob_idx, LQ_tail, SQ_tail, rob_head
    );

    modport slave (
        input  alloc_valid, alloc_fu_sel, commit_valid, mispredict, mispredict_rob_idx,
        output rob_ready, ld_ready, st_ready, rob_idx, LQ_tail, SQ_tail, rob_head
    );

endinterface

// File: rtl/dispatch_alloc_ctrl_circ_ptr.sv
// Circular head/tail pointer pair with wrap bit, used for the LQ and SQ.
module circ_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         load_i,
    input  logic [W:0]   load_val_i,
    output logic [W:0]   tail_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [W:0] PTR_ONE = (W+1)'(1);

    logic [W:0] head_q, head_d;
    logic [W:0] tail_q, tail_d;

    // Next pointers: a rollback load overrides any push in the same cycle.
    always_comb begin
        head_d = pop_i ? head_q + PTR_ONE : head_q;
        tail_d = tail_q;
        if (load_i) begin
            tail_d = load_val_i;
        end else if (push_i) begin
            tail_d = tail_q + PTR_ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign tail_o  = tail_q;
    assign full_o  = (head_q[W] != tail_q[W]) && (head_q[W-1:0] == tail_q[W-1:0]);
    assign empty_o = (head_q == tail_q);

endmodule

// File: rtl/dispatch_alloc_ctrl.sv
// ROB/LQ/SQ allocation controller: in-order alloc, in-order commit, mispredict rollback.
module dispatch_alloc_ctrl
    import dispatch_alloc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    dispatch_alloc_ctrl_if.slave  bus_if
);

    localparam logic [ROB_W:0] ROB_ONE = (ROB_W+1)'(1);
    localparam logic [LQ_W:0]  LQ_ONE  = (LQ_W+1)'(1);
    localparam logic [SQ_W:0]  SQ_ONE  = (SQ_W+1)'(1);

    logic [ROB_W:0]     rob_head_q, rob_head_d;
    logic [ROB_W:0]     rob_tail_q, rob_tail_d;
    logic [ROB_DEPTH-1:0] is_ld_q, is_st_q;
    logic [LQ_W:0]      lq_snap_q [ROB_DEPTH];
    logic [SQ_W:0]      sq_snap_q [ROB_DEPTH];

    logic [LQ_W:0]      lq_tail;
    logic [SQ_W:0]      sq_tail;
    logic               lq_full, lq_empty, sq_full, sq_empty;

    alloc_kind_e        kind;
    logic               rob_full, rob_empty, res_ok;
    logic               alloc_fire, commit_fire, mis_fire, mis_in_range;
    logic [ROB_W:0]     rob_count, mis_ext;
    logic [ROB_W-1:0]   head_idx, tail_idx, mis_idx, mis_off;
    logic               lq_push, lq_pop, sq_push, sq_pop;
    logic [LQ_W:0]      lq_snap_new;
    logic [SQ_W:0]      sq_snap_new;

    assign head_idx  = rob_head_q[ROB_W-1:0];
    assign tail_idx  = rob_tail_q[ROB_W-1:0];
    assign mis_idx   = bus_if.mispredict_rob_idx;
    assign rob_count = rob_tail_q - rob_head_q;
    assign rob_full  = (rob_head_q[ROB_W] != rob_tail_q[ROB_W]) && (head_idx == tail_idx);
    assign rob_empty = (rob_head_q == rob_tail_q);
    assign kind      = classify(bus_if.alloc_fu_sel);

    // Decide which requests actually fire and where the ROB pointers go next.
    always_comb begin
        res_ok       = !rob_full && !(kind == ALLOC_LD && lq_full) && !(kind == ALLOC_ST && sq_full);
        alloc_fire   = bus_if.alloc_valid && !bus_if.mispredict && res_ok;
        commit_fire  = bus_if.commit_valid && !rob_empty;
        mis_off      = mis_idx - head_idx;
        mis_in_range = {1'b0, mis_off} < rob_count;
        mis_fire     = bus_if.mispredict && mis_in_range;
        mis_ext      = {(mis_idx < head_idx) ? ~rob_head_q[ROB_W] : rob_head_q[ROB_W], mis_idx};

        rob_head_d = commit_fire ? rob_head_q + ROB_ONE : rob_head_q;
        rob_tail_d = rob_tail_q;
        if (mis_fire) begin
            rob_tail_d = mis_ext + ROB_ONE;
        end else if (alloc_fire) begin
            rob_tail_d = rob_tail_q + ROB_ONE;
        end

        lq_push     = alloc_fire && (kind == ALLOC_LD);
        sq_push     = alloc_fire && (kind == ALLOC_ST);
        lq_pop      = commit_fire && is_ld_q[head_idx];
        sq_pop      = commit_fire && is_st_q[head_idx];
        lq_snap_new = lq_push ? lq_tail + LQ_ONE : lq_tail;
        sq_snap_new = sq_push ? sq_tail + SQ_ONE : sq_tail;
    end

    // ROB pointers and per-entry metadata captured at allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_head_q <= '0;
            rob_tail_q <= '0;
            is_ld_q    <= '0;
            is_st_q    <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                lq_snap_q[i] <= '0;
                sq_snap_q[i] <= '0;
            end
        end else begin
            rob_head_q <= rob_head_d;
            rob_tail_q <= rob_tail_d;
            if (alloc_fire) begin
                is_ld_q[tail_idx]   <= (kind == ALLOC_LD);
                is_st_q[tail_idx]   <= (kind == ALLOC_ST);
                lq_snap_q[tail_idx] <= lq_snap_new;
                sq_snap_q[tail_idx] <= sq_snap_new;
            end
        end
    end

    circ_ptr_ctrl #(.DEPTH(LQ_DEPTH), .W(LQ_W)) u_lq (
        .clk        (clk),
        .rst        (rst),
        .push_i     (lq_push),
        .pop_i      (lq_pop),
        .load_i     (mis_fire),
        .load_val_i (lq_snap_q[mis_idx]),
        .tail_o     (lq_tail),
        .full_o     (lq_full),
        .empty_o    (lq_empty)
    );

    circ_ptr_ctrl #(.DEPTH(SQ_DEPTH), .W(SQ_W)) u_sq (
        .clk        (clk),
        .rst        (rst),
        .push_i     (sq_push),
        .pop_i      (sq_pop),
        .load_i     (mis_fire),
        .load_val_i (sq_snap_q[mis_idx]),
        .tail_o     (sq_tail),
        .full_o     (sq_full),
        .empty_o    (sq_empty)
    );

    assign bus_if.rob_ready = !rob_full;
    assign bus_if.ld_ready  = !lq_full;
    assign bus_if.st_ready  = !sq_full;
    assign bus_if.rob_idx   = tail_idx;
    assign bus_if.LQ_tail   = lq_tail[LQ_W-1:0];
    assign bus_if.SQ_tail   = sq_tail[SQ_W-1:0];
    assign bus_if.rob_head  = head_idx;

    // Protocol checks: the offending request is dropped in hardware, these just flag it.
    a_alloc_not_ready: assert property (@(posedge clk) disable iff (rst)
        !(bus_if.alloc_valid && !bus_if.mispredict && !res_ok));
    a_commit_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus_if.commit_valid && rob_empty));
    a_mispredict_range: assert property (@(posedge clk) disable iff (rst)
        !(bus_if.mispredict && !mis_in_range));
    a_lsq_underflow: assert property (@(posedge clk) disable iff (rst)
        !((lq_pop && lq_empty) || (sq_pop && sq_empty)));

endmodule

// File: tb/tb_dispatch_alloc_ctrl.sv
// Directed self-checking bench for dispatch_alloc_ctrl.
module tb_dispatch_alloc_ctrl;
    import dispatch_alloc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   compareCount = 0;
    int   failCount    = 0;

    dispatch_alloc_ctrl_if ifc ();

    dispatch_alloc_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (ifc)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [2:0] fu, input logic cv,
                                 input logic mp, input logic [2:0] mi);
        ifc.alloc_valid        = av;
        ifc.alloc_fu_sel       = fu;
        ifc.commit_valid       = cv;
        ifc.mispredict         = mp;
        ifc.mispredict_rob_idx = mi;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic checkIdle(input string tag, input logic [2:0] idx, input logic [2:0] head);
        checkOutput({tag, "_rob_ready"}, 32'(ifc.rob_ready), 32'd1);
        checkOutput({tag, "_ld_ready"},  32'(ifc.ld_ready),  32'd1);
        checkOutput({tag, "_st_ready"},  32'(ifc.st_ready),  32'd1);
        checkOutput({tag, "_rob_idx"},   32'(ifc.rob_idx),   32'(idx));
        checkOutput({tag, "_rob_head"},  32'(ifc.rob_head),  32'(head));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        #12;
        checkIdle("reset", 3'd0, 3'd0);
        checkOutput("reset_lq_tail", 32'(ifc.LQ_tail), 32'd0);
        checkOutput("reset_sq_tail", 32'(ifc.SQ_tail), 32'd0);
        #1;
        rst = 1'b0;
        tick();

        // Eight ALU allocations fill the ROB.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, FU_ALU, 1'b0, 1'b0, 3'd0);
            checkOutput($sformatf("alu%0d_idx", i), 32'(ifc.rob_idx), 32'(i));
            checkOutput($sformatf("alu%0d_lq", i), 32'(ifc.LQ_tail), 32'd0);
            checkOutput($sformatf("alu%0d_sq", i), 32'(ifc.SQ_tail), 32'd0);
            checkOutput($sformatf("alu%0d_ready", i), 32'(ifc.rob_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("full_rob_ready", 32'(ifc.rob_ready), 32'd0);
        checkOutput("full_rob_idx", 32'(ifc.rob_idx), 32'd0);

        // Drain the ROB.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, FU_ALU, 1'b1, 1'b0, 3'd0);
            checkOutput($sformatf("drain%0d_head", i), 32'(ifc.rob_head), 32'(i));
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkIdle("drained", 3'd0, 3'd0);

        // Four loads fill the LQ, then one store.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b0, 3'd0);
            checkOutput($sformatf("ld%0d_lq", i), 32'(ifc.LQ_tail), 32'(i));
            checkOutput($sformatf("ld%0d_ldready", i), 32'(ifc.ld_ready), 32'd1);
            checkOutput($sformatf("ld%0d_idx", i), 32'(ifc.rob_idx), 32'(i));
            tick();
        end
        applyStimulus(1'b1, FU_STORE, 1'b0, 1'b0, 3'd0);
        checkOutput("lqfull_ld_ready", 32'(ifc.ld_ready), 32'd0);
        checkOutput("lqfull_st_ready", 32'(ifc.st_ready), 32'd1);
        checkOutput("st_sq_tail", 32'(ifc.SQ_tail), 32'd0);
        checkOutput("st_rob_idx", 32'(ifc.rob_idx), 32'd4);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("post_st_sq_tail", 32'(ifc.SQ_tail), 32'd1);
        checkOutput("post_st_ld_ready", 32'(ifc.ld_ready), 32'd0);
        checkOutput("post_st_rob_idx", 32'(ifc.rob_idx), 32'd5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, FU_ALU, 1'b1, 1'b0, 3'd0);
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkIdle("lsq_drained", 3'd5, 3'd5);
        checkOutput("lsq_drained_lq", 32'(ifc.LQ_tail), 32'd0);
        checkOutput("lsq_drained_sq", 32'(ifc.SQ_tail), 32'd1);

        // ld, br, ld, st then mispredict on the branch.
        doReset();
        applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b1, FU_BR, 1'b0, 1'b0, 3'd0);
        checkOutput("br_lq", 32'(ifc.LQ_tail), 32'd1);
        tick();
        applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b1, FU_STORE, 1'b0, 1'b0, 3'd0);
        checkOutput("seq_st_lq", 32'(ifc.LQ_tail), 32'd2);
        checkOutput("seq_st_idx", 32'(ifc.rob_idx), 32'd3);
        tick();
        applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b1, 3'd1);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("mis_rob_idx", 32'(ifc.rob_idx), 32'd2);
        checkOutput("mis_lq_tail", 32'(ifc.LQ_tail), 32'd1);
        checkOutput("mis_sq_tail", 32'(ifc.SQ_tail), 32'd0);
        checkOutput("mis_rob_head", 32'(ifc.rob_head), 32'd0);
        applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b0, 3'd0);
        checkOutput("fresh_rob_idx", 32'(ifc.rob_idx), 32'd2);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("fresh_next_idx", 32'(ifc.rob_idx), 32'd3);
        checkOutput("fresh_next_lq", 32'(ifc.LQ_tail), 32'd2);

        // Commit the head load while mispredicting on it: ROB and LQ become empty.
        applyStimulus(1'b0, FU_ALU, 1'b1, 1'b1, 3'd0);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkIdle("cm", 3'd1, 3'd1);
        checkOutput("cm_lq_tail", 32'(ifc.LQ_tail), 32'd1);
        checkOutput("cm_sq_tail", 32'(ifc.SQ_tail), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, FU_LOAD, 1'b0, 1'b0, 3'd0);
            checkOutput($sformatf("cm_ld%0d_ready", i), 32'(ifc.ld_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("cm_lq_full", 32'(ifc.ld_ready), 32'd0);

        // Fill, then commit three while allocating across the index wrap.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, FU_ALU, 1'b0, 1'b0, 3'd0);
            checkOutput($sformatf("wrap_fill%0d_idx", i), 32'(ifc.rob_idx), 32'(i));
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b1, 1'b0, 3'd0);
        checkOutput("wrap_commit_no_bypass", 32'(ifc.rob_ready), 32'd0);
        tick();
        checkOutput("wrap_head1", 32'(ifc.rob_head), 32'd1);
        checkOutput("wrap_ready1", 32'(ifc.rob_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, FU_ALU, (i < 2) ? 1'b1 : 1'b0, 1'b0, 3'd0);
            checkOutput($sformatf("wrap_alloc%0d_idx", i), 32'(ifc.rob_idx), 32'(i));
            checkOutput($sformatf("wrap_alloc%0d_ready", i), 32'(ifc.rob_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("wrap_head3", 32'(ifc.rob_head), 32'd3);
        checkOutput("wrap_full_again", 32'(ifc.rob_ready), 32'd0);
        checkOutput("wrap_tail_idx", 32'(ifc.rob_idx), 32'd3);

        // Mispredict on an index below head: wrap bit must be reconstructed.
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b1, 3'd1);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("wrapmis_idx", 32'(ifc.rob_idx), 32'd2);
        checkOutput("wrapmis_ready", 32'(ifc.rob_ready), 32'd1);
        checkOutput("wrapmis_head", 32'(ifc.rob_head), 32'd3);
        applyStimulus(1'b1, FU_ALU, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("wrapmis_refill_full", 32'(ifc.rob_ready), 32'd0);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_rst", 3'd0, 3'd0);
        checkOutput("async_rst_lq", 32'(ifc.LQ_tail), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, FU_STORE, 1'b0, 1'b0, 3'd0);
        checkOutput("post_rst_idx", 32'(ifc.rob_idx), 32'd0);
        tick();
        applyStimulus(1'b0, FU_ALU, 1'b0, 1'b0, 3'd0);
        checkOutput("post_rst_idx1", 32'(ifc.rob_idx), 32'd1);
        checkOutput("post_rst_sq", 32'(ifc.SQ_tail), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/dispatch_alloc_ctrl.md
Name: dispatch_alloc_ctrl

Overview:
Allocation controller for the decode/dispatch stage.
- Hands out the ROB index, LQ tail and SQ tail that decode attaches to each instruction.
- Drives the rob_ready/ld_ready/st_ready back-pressure that decode uses to form its ready signal.
- Frees entries in order at commit.
- On a branch mispredict, rolls all three allocation pointers back to the state just after the mispredicting instruction.

Parameters:
ROB_DEPTH, 8, ROB entries (power of 2); ROB_W = log2(ROB_DEPTH) = 3
LQ_DEPTH, 4, load-queue entries (power of 2); LQ_W = 2
SQ_DEPTH, 4, store-queue entries (power of 2); SQ_W = 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alloc_valid  in  1  decode fires an instruction this cycle (decode_valid)
alloc_fu_sel  in  3  FU select of that instruction; 6 = load, 7 = store
rob_ready  out  1  ROB has at least one free entry
ld_ready  out  1  LQ has at least one free entry
st_ready  out  1  SQ has at least one free entry
rob_idx  out  ROB_W  ROB index for the current allocation (ROB tail)
LQ_tail  out  LQ_W  LQ slot for the current allocation
SQ_tail  out  SQ_W  SQ slot for the current allocation
rob_head  out  ROB_W  oldest live ROB index
commit_valid  in  1  ROB head retires this cycle
mispredict  in  1  flush everything younger than mispredict_rob_idx
mispredict_rob_idx  in  ROB_W  ROB index of the mispredicting branch/jump

Behaviour:
- State:
  - ROB head/tail with an extra wrap bit (ROB_W+1 bits each).
  - LQ head/tail and SQ head/tail, each with a wrap bit.
  - Per-ROB-entry metadata written at allocation: is_ld, is_st, lq_snap and sq_snap. The snaps are the extended LQ/SQ tails *after* this entry's allocation.
- Reset (async, rst=1): all pointers and metadata cleared. Outputs: rob_ready=1, ld_ready=1, st_ready=1, rob_idx=0, LQ_tail=0, SQ_tail=0, rob_head=0.
- Ready flags are registered-state only, with no combinational path from alloc_valid:
  - rob_ready = (rob_tail - rob_head) != ROB_DEPTH.
  - ld_ready and st_ready follow the same rule on their own pointers.
- Allocation, when alloc_valid && !mispredict:
  - rob_idx, LQ_tail and SQ_tail present their current values combinationally in the same cycle.
  - At the clock edge, rob_tail++.
  - If fu_sel==6: lq_tail++ and is_ld=1. If fu_sel==7: sq_tail++ and is_st=1.
  - Entry metadata is written with the post-increment snaps.
- alloc_valid while the required resource is not ready is a protocol violation. It is ignored (no state change) and flagged by an assertion.
- Commit, when commit_valid: rob_head++. If is_ld[head], lq_head++. If is_st[head], sq_head++.
- commit_valid with the ROB empty is ignored (assertion).
- Mispredict (m = mispredict_rob_idx):
  - alloc_valid is ignored.
  - rob_tail <= extended(m)+1, where the wrap bit is reconstructed relative to rob_head: m < head[ROB_W-1:0] means the wrap bit is head's wrap bit inverted.
  - lq_tail <= lq_snap[m]; sq_tail <= sq_snap[m].
  - Rolled-back entries become free on the next cycle; the ready flags update accordingly.
- Simultaneous commit + mispredict: both apply in the same edge (head advances, tail rolls back). If m == head and the head commits, the result is an empty ROB.
- A mispredict with m outside the live range [head, tail) is ignored (assertion).
- Latency: allocation and free both take effect one cycle after the request; there is no bypass from commit to ready within the same cycle.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. Full is detected via the differing wrap bit with equal index bits.

Decomposition:
- Shared package: FU_LOAD=3'd6, FU_STORE=3'd7, and the ROB/LQ/SQ width localparams.
- One natural sub-module, circ_ptr_ctrl (parameterised DEPTH), instantiated for LQ and SQ. It provides head/tail, increment, load-tail rollback and full/empty.

Test Plan:
- Reset then 8 ALU allocs, no commits -> rob_idx 0..7; rob_ready=0 after the 8th edge; LQ_tail=SQ_tail=0 throughout.
- 4 loads plus 1 store -> LQ_tail 0,1,2,3; ld_ready=0 after the 4th load while st_ready stays 1; SQ_tail=0 at the store, then 1.
- Sequence ld(0), br(1), ld(2), st(3), mispredict idx 1 -> next cycle rob_idx=2, LQ_tail=1, SQ_tail=0; a fresh alloc receives ROB 2.
- Fill ROB, commit 3 while allocating around the wrap -> rob_idx sequence 0..7,0,1,2; no false full or empty; rob_head=3.
- Commit head (a load at idx 0) in the same cycle as mispredict idx 0 -> ROB empty, lq_head=lq_tail, all readies =1.
- Assert rst mid-sequence, asynchronously mid-cycle -> outputs return to their reset values immediately, without waiting for a clock edge.
